// File: rtl/modbus_rx_framer_pkg.sv
// Shared types and constants for the Modbus RTU receive framer and its CRC-16 engine.
package modbus_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_SILENCE,
        ST_IDLE,
        ST_RECV,
        ST_DONE
    } mb_state_e;

    localparam logic [7:0]  MB_BCAST_ADDR    = 8'h00;
    localparam int unsigned MB_MIN_FRAME_LEN = 4;
    localparam logic [15:0] MB_CRC_RESIDUE   = 16'h0000;
    localparam logic [15:0] MB_CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] MB_CRC_POLY      = 16'hA001;

    // One byte through the reflected CRC-16/MODBUS update.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ MB_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/modbus_rx_framer_crc.sv
// Byte-wide CRC-16 engine (poly 0xA001 reflected, init 0xFFFF); clear has priority over enable.
module Crc
    import modbus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            crc_q <= MB_CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc16_byte(crc_q, data_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/modbus_rx_framer.sv
// Modbus RTU receive framer: t1.5/t3.5 framing, CRC sequencing, byte forwarding and verdict.
// Optional slave-address filter enabled by defining MODBUS_ADDR_FILTER_EN.
module modbus_rx_framer
    import modbus_pkg::*;
#(
    parameter int unsigned T15_CYCLES = 7500,
    parameter int unsigned T35_CYCLES = 17500,
    parameter int unsigned MAX_LEN    = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    input  logic [7:0] dev_addr,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic [8:0] out_index,
    output logic       frame_end,
    output logic       frame_ok,
    output logic [8:0] frame_len
);

    localparam int unsigned SIL_W = $clog2(T35_CYCLES + 1);
    localparam int unsigned LEN_W = 9;
    localparam logic [SIL_W-1:0] SIL_T15 = SIL_W'(T15_CYCLES);
    localparam logic [SIL_W-1:0] SIL_T35 = SIL_W'(T35_CYCLES);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MB_MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

    mb_state_e        state_q;
    logic [SIL_W-1:0] sil_q;
    logic [SIL_W-1:0] sil_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic             bad_q;
    logic             acc_q;
    logic [7:0]       out_data_q;
    logic             out_valid_q;
    logic [LEN_W-1:0] out_index_q;
    logic             frame_end_q;
    logic             frame_ok_q;
    logic [LEN_W-1:0] frame_len_q;

    logic             crc_clr_c;
    logic             crc_en_c;
    logic [15:0]      crc_c;
    logic             addr_ok_c;
    logic             verdict_c;

    // Engine sits at init whenever no frame is in progress, so the first byte sees 0xFFFF.
    assign crc_clr_c = (state_q == ST_WAIT_SILENCE) || (state_q == ST_DONE) ||
                       ((state_q == ST_IDLE) && !rx_valid);
    assign crc_en_c  = rx_valid && ((state_q == ST_IDLE) || (state_q == ST_RECV));

    Crc u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (crc_clr_c),
        .en_i   (crc_en_c),
        .data_i (rx_data),
        .crc_o  (crc_c)
    );

`ifdef MODBUS_ADDR_FILTER_EN
    assign addr_ok_c = (rx_data == dev_addr) || (rx_data == MB_BCAST_ADDR);
`else
    logic unused_dev_addr;
    assign unused_dev_addr = ^dev_addr;
    assign addr_ok_c       = 1'b1;
`endif

    assign sil_d     = (sil_q == SIL_T35) ? sil_q : sil_q + SIL_W'(1);
    assign len_d     = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
    assign verdict_c = !bad_q && (len_q >= LEN_MIN) && (len_q <= LEN_MAX) &&
                       (crc_c == MB_CRC_RESIDUE);

    // Silence counter holds "cycles since last byte": a byte loads 1, expiry at T35.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_SILENCE;
            sil_q       <= '0;
            len_q       <= '0;
            bad_q       <= 1'b0;
            acc_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            frame_end_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_len_q <= '0;
        end else begin
            out_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_len_q <= '0;
            case (state_q)
                ST_WAIT_SILENCE: begin
                    if (rx_valid) begin
                        sil_q <= SIL_W'(1);
                    end else if (sil_q == SIL_T35) begin
                        state_q <= ST_IDLE;
                    end else begin
                        sil_q <= sil_d;
                    end
                end
                ST_IDLE: begin
                    if (rx_valid) begin
                        state_q <= ST_RECV;
                        sil_q   <= SIL_W'(1);
                        len_q   <= LEN_W'(1);
                        bad_q   <= rx_err;
                        acc_q   <= addr_ok_c;
                        if (addr_ok_c) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= rx_data;
                            out_index_q <= '0;
                        end
                    end
                end
                ST_RECV: begin
                    if (rx_valid) begin
                        sil_q <= SIL_W'(1);
                        len_q <= len_d;
                        bad_q <= bad_q || rx_err || (sil_q >= SIL_T15);
                        if (acc_q && (len_q < LEN_MAX)) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= rx_data;
                            out_index_q <= len_q;
                        end
                    end else if (sil_q == SIL_T35) begin
                        state_q     <= ST_DONE;
                        frame_end_q <= acc_q;
                        frame_ok_q  <= acc_q && verdict_c;
                        frame_len_q <= acc_q ? len_q : '0;
                    end else begin
                        sil_q <= sil_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_WAIT_SILENCE;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign frame_end = frame_end_q;
    assign frame_ok  = frame_ok_q;
    assign frame_len = frame_len_q;

endmodule

// File: tb/tb_modbus_rx_framer.sv
// Scoreboard bench for modbus_rx_framer; honours MODBUS_ADDR_FILTER_EN when defined.
module tb_modbus_rx_framer;

    localparam int unsigned T15  = 30;
    localparam int unsigned T35  = 70;
    localparam int unsigned MAXL = 12;
    localparam int unsigned CHAR = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic [7:0] dev_addr = 8'h01;
    logic [7:0] out_data;
    logic       out_valid;
    logic [8:0] out_index;
    logic       frame_end;
    logic       frame_ok;
    logic [8:0] frame_len;

    modbus_rx_framer #(
        .T15_CYCLES (T15),
        .T35_CYCLES (T35),
        .MAX_LEN    (MAXL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .dev_addr  (dev_addr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_index (out_index),
        .frame_end (frame_end),
        .frame_ok  (frame_ok),
        .frame_len (frame_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int last_cyc = 0;
    logic [7:0] frm[$];
    int exp_data[$];
    int exp_idx[$];
    int exp_ok[$];
    int exp_len[$];
    int exp_cyc[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pop expectations as the DUT produces output, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                check_eq("out_expected", int'(exp_data.size() > 0), 1);
                if (exp_data.size() > 0) begin
                    check_eq("out_data", int'(out_data), exp_data.pop_front());
                    check_eq("out_index", int'(out_index), exp_idx.pop_front());
                end
            end
            if (frame_end) begin
                check_eq("end_expected", int'(exp_ok.size() > 0), 1);
                if (exp_ok.size() > 0) begin
                    check_eq("frame_ok", int'(frame_ok), exp_ok.pop_front());
                    check_eq("frame_len", int'(frame_len), exp_len.pop_front());
                    check_eq("frame_end_cycle", cyc, exp_cyc.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e);
        rx_data  = d;
        rx_err   = e;
        rx_valid = 1'b1;
        last_cyc = cyc;
        tick(1);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    // Sends frm; byte gap_at follows a gap of gap_len cycles, byte err_at carries rx_err.
    task automatic send_frame(input int gap_at, input int gap_len, input int err_at,
                              input bit fwd, input int ok);
        for (int i = 0; i < frm.size(); i++) begin
            if (i > 0) tick(((i == gap_at) ? gap_len : int'(CHAR)) - 1);
            if (fwd && i < int'(MAXL)) begin
                exp_data.push_back(int'(frm[i]));
                exp_idx.push_back(i);
            end
            send_byte(frm[i], i == err_at);
        end
        if (fwd) begin
            exp_ok.push_back(ok);
            exp_len.push_back((frm.size() > int'(MAXL)) ? int'(MAXL) + 1 : frm.size());
            exp_cyc.push_back(last_cyc + int'(T35) + 1);
        end
    endtask

    task automatic append_crc();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (frm[i]) begin
            c ^= {8'h00, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
    endtask

    task automatic good_frame(input logic [7:0] addr);
        frm = {addr, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        append_crc();
    endtask

    task automatic quiet();
        tick(int'(T35) + 10);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_out_valid"}, int'(out_valid), 0);
        check_eq({tag, "_out_data"},  int'(out_data), 0);
        check_eq({tag, "_out_index"}, int'(out_index), 0);
        check_eq({tag, "_frame_end"}, int'(frame_end), 0);
        check_eq({tag, "_frame_ok"},  int'(frame_ok), 0);
        check_eq({tag, "_frame_len"}, int'(frame_len), 0);
    endtask

    initial begin
        tick(3);
        check_cleared("reset");
        rst = 1'b0;
        tick(int'(T35) + 5);

        // Reference request with known CRC 0x0A84.
        frm = {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        send_frame(-1, 0, -1, 1'b1, 1);
        quiet();

        frm[7] = 8'h0B;
        send_frame(-1, 0, -1, 1'b1, 0);
        quiet();

        frm[7] = 8'h0A;
        send_frame(4, int'(T15) + 10, -1, 1'b1, 0);
        quiet();

        send_frame(-1, 0, 2, 1'b1, 0);
        quiet();
        good_frame(8'h01);
        send_frame(-1, 0, -1, 1'b1, 1);
        quiet();

        // Byte landing exactly at T35 still belongs to the frame, but breaks t1.5.
        send_frame(5, int'(T35), -1, 1'b1, 0);
        quiet();

        // Byte during the DONE cycle is dropped; the next frame starts cleanly.
        send_frame(-1, 0, -1, 1'b1, 1);
        tick(int'(T35));
        send_byte(8'h55, 1'b0);
        tick(int'(CHAR) - 1);
        send_frame(-1, 0, -1, 1'b1, 1);
        quiet();

        frm = {8'h01, 8'h03, 8'h05};
        send_frame(-1, 0, -1, 1'b1, 0);
        quiet();

        frm = {8'h01, 8'h10, 8'h00, 8'h01, 8'h00, 8'h02, 8'h04, 8'h12, 8'h34, 8'h56};
        append_crc();
        send_frame(-1, 0, -1, 1'b1, 1);
        quiet();

        frm = {};
        for (int i = 0; i < int'(MAXL) + 2; i++) frm.push_back(8'(i + 1));
        send_frame(-1, 0, -1, 1'b1, 0);
        quiet();

        dev_addr = 8'h02;
        good_frame(8'h01);
`ifdef MODBUS_ADDR_FILTER_EN
        send_frame(-1, 0, -1, 1'b0, 0);
`else
        send_frame(-1, 0, -1, 1'b1, 1);
`endif
        quiet();
        good_frame(8'h00);
        send_frame(-1, 0, -1, 1'b1, 1);
        quiet();
        dev_addr = 8'h01;

        // Reset after byte 3 abandons the frame; the post-reset silence must be honoured.
        good_frame(8'h01);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick(int'(CHAR) - 1);
            exp_data.push_back(int'(frm[i]));
            exp_idx.push_back(i);
            send_byte(frm[i], 1'b0);
        end
        tick(2);
        rst = 1'b1;
        tick(2);
        check_cleared("midreset");
        rst = 1'b0;
        send_frame(-1, 0, -1, 1'b0, 0);
        quiet();
        send_frame(-1, 0, -1, 1'b1, 1);
        quiet();

        check_eq("pending_bytes", exp_data.size(), 0);
        check_eq("pending_frames", exp_ok.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modbus_rx_framer.md
# modbus_rx_framer

Modbus RTU receive-side frame sequencer. It sits between the UART byte receiver and the Modbus request decoder, and drives the shared CRC-16 engine: resets it at each frame start, clocks each received byte into it, and judges the residue at frame end. Frame boundaries come from the RTU silent-interval rules (t1.5 / t3.5). The block streams accepted bytes downstream and reports a per-frame verdict.

## Interface
- `T15_CYCLES`, default 7500: clk cycles in 1.5 character times.
- `T35_CYCLES`, default 17500: clk cycles in 3.5 character times. Must be greater than `T15_CYCLES`.
- `MAX_LEN`, default 256: maximum legal frame length in bytes, including the CRC.
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `rx_data`, in, 8: received byte.
- `rx_valid`, in, 1: one-cycle strobe qualifying `rx_data`.
- `rx_err`, in, 1: UART framing/parity error. Sampled with `rx_valid`.
- `dev_addr`, in, 8: own slave address.
- `out_data`, out, 8: accepted byte.
- `out_valid`, out, 1: strobe for `out_data`.
- `out_index`, out, 9: byte position in the frame, 0-based.
- `frame_end`, out, 1: one-cycle pulse at the end of a frame.
- `frame_ok`, out, 1: frame verdict. Valid only while `frame_end` is high.
- `frame_len`, out, 9: byte count including the CRC. Valid while `frame_end` is high.

## Operation
- States:
  - `WAIT_SILENCE`: entered at reset. Bytes are ignored. The silence counter restarts on every `rx_valid`. Reaching `T35_CYCLES` moves to `IDLE`.
  - `IDLE`: `rx_valid` starts a frame and moves to `RECV`. `len` is set to 1, `bad` is set to `rx_err`, and the byte is fed to the CRC engine.
  - `RECV`: each `rx_valid` increments `len`, feeds the CRC engine, and ORs `rx_err` into `bad`.
    - A byte arriving with silence count ≥ `T15_CYCLES` sets `bad` (t1.5 violation). The byte is still counted.
    - When the count reaches `T35_CYCLES`, go to `DONE`.
  - `DONE`: one cycle. Pulse `frame_end`, then go to `IDLE`.
- CRC control:
  - The engine reset input is held high in `WAIT_SILENCE`, `DONE`, and in `IDLE` on cycles without `rx_valid`. The engine therefore holds 0xFFFF when the first byte arrives.
  - The engine enable is high exactly on each accepted `rx_valid` cycle.
- Verdict: `frame_ok = !bad && len >= 4 && len <= MAX_LEN && crc_out == 16'h0000`. The residue is checked after both CRC bytes (low byte first) have been fed.
- Length: `len` saturates at `MAX_LEN+1`. Bytes beyond `MAX_LEN` are not forwarded on `out_*`.
- Silence counter: saturates at `T35_CYCLES`; it never wraps.
- Reset mid-frame: the frame is abandoned with no `frame_end`, all outputs clear, and the block returns to `WAIT_SILENCE`.
- Reset values: `out_data` = 0, `out_valid` = 0, `out_index` = 0, `frame_end` = 0, `frame_ok` = 0, `frame_len` = 0.

## Timing
- `out_valid`, `out_data` and `out_index` are registered: they appear 1 cycle after the corresponding `rx_valid`.
- `frame_end` is asserted exactly `T35_CYCLES + 1` cycles after the last `rx_valid` of the frame.
- The CRC engine output used for the verdict is the value one cycle after the last enable. It is stable throughout the silence period.
- `rx_valid` in the same cycle the silence counter reaches `T35_CYCLES` in `RECV`: the byte belongs to the current frame and the counter restarts. Expiry takes effect only with no byte that cycle.
- `rx_valid` during `DONE`: dropped. The block enters `IDLE`, and the next frame starts only with a later byte.

## Configuration
- `MODBUS_ADDR_FILTER_EN` defined:
  - Byte 0 is compared with `dev_addr` and with broadcast 0x00.
  - On a mismatch the frame is consumed silently: no `out_valid`, no `frame_end`. The CRC is still sequenced and timing is unchanged.
  - Acceptance is decided before byte 0 is forwarded.
- Not defined: every frame is forwarded and reported, and `dev_addr` is ignored.

## Structure
- `modbus_pkg` holds:
  - the state enum;
  - `MB_BCAST_ADDR` = 8'h00;
  - `MB_MIN_FRAME_LEN` = 4;
  - the CRC residue constant 16'h0000.
- Exactly one sub-module: the existing `Crc` CRC-16 engine (polynomial 0xA001 reflected, init 0xFFFF), instantiated once. The silence counter and length counter stay inline.

## Test plan
- Bytes 01 03 00 00 00 01 84 0A, 1 character time apart, `dev_addr` = 01 → 8 `out_valid` pulses with indices 0–7, then `frame_end` with `frame_ok` = 1 and `frame_len` = 8, `T35_CYCLES + 1` cycles after the last byte.
- Same frame with the last byte changed to 0B → `frame_end` with `frame_ok` = 0 and `frame_len` = 8.
- Same frame with a gap of `T15_CYCLES + 10` cycles before byte 4 → `frame_ok` = 0, `frame_len` = 8.
- `rx_err` = 1 on byte 2 → `frame_ok` = 0. A following valid frame after `T35_CYCLES` of silence → `frame_ok` = 1 (the CRC was reset in between).
- `MODBUS_ADDR_FILTER_EN` defined, `dev_addr` = 02, valid frame to address 01 → no `out_valid` and no `frame_end`. The same frame with address 00 and a correct CRC → `frame_ok` = 1.
- `rst` pulsed after byte 3 → no `frame_end`. A frame sent before `T35_CYCLES` of post-reset silence is ignored. A frame after that silence → `frame_ok` = 1.
